// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg
//   Shared definitions for the memory-mapped PS/2 keyboard receiver:
//   deframer state encoding, register offsets (Address[3:2]) and the
//   bit positions used inside the STATUS and CTRL registers.
package ps2_kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rxState_e;

  // Register select values as seen on Address[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // STATUS register layout
  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_PERR      = 3;
  localparam int STAT_FERR      = 4;
  localparam int STAT_COUNT_LSB = 5;
  localparam int STAT_COUNT_MSB = 10;

  // CTRL register layout
  localparam int CTRL_EN    = 0;
  localparam int CTRL_IE    = 1;
  localparam int CTRL_FLUSH = 2;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones
  function automatic logic oddParityOk(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame
//   Receives 11-bit PS/2 frames (start, 8 data LSB first, odd parity, stop).
//   Both PS/2 lines are double-flop synchronised; the clock line is then
//   glitch filtered and its filtered falling edge becomes the sample strobe.
//   Ports:
//     clk_i, rstN_i    system clock, asynchronous active-low reset
//     en_i             receiver enable; when low the deframer is held idle
//     ps2Clk_i         raw keyboard clock (asynchronous)
//     ps2Dat_i         raw keyboard data  (asynchronous)
//     byteValid_o      one-cycle pulse with a correctly received byte
//     byte_o           received byte, valid with byteValid_o
//     perr_o, ferr_o   one-cycle pulses for parity / stop-bit errors
module ps2_rx_frame
  import ps2_kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_i,
  input  logic       rstN_i,
  input  logic       en_i,
  input  logic       ps2Clk_i,
  input  logic       ps2Dat_i,
  output logic       byteValid_o,
  output logic [7:0] byte_o,
  output logic       perr_o,
  output logic       ferr_o
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]     clkSync_q, datSync_q;
  logic           filtClk_q, filtClk_d;
  logic [FCW-1:0] filtCnt_q, filtCnt_d;
  logic           strobe_q, strobe_d;

  rxState_e       state_q, state_d;
  logic [2:0]     bitCnt_q, bitCnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           parity_q, parity_d;
  logic [TCW-1:0] toCnt_q, toCnt_d;
  logic           byteValid_q, byteValid_d;
  logic [7:0]     byte_q, byte_d;
  logic           perr_q, perr_d;
  logic           ferr_q, ferr_d;

  logic           datBit;
  logic           timeoutHit;

  assign datBit     = datSync_q[1];
  assign timeoutHit = (toCnt_q == TCW'(TIMEOUT_CYCLES - 1));

  // The filtered clock only follows the synced line after FILTER_LEN
  // consecutive differing samples; a 1->0 flip produces the strobe.
  always_comb begin
    filtClk_d = filtClk_q;
    filtCnt_d = '0;
    strobe_d  = 1'b0;
    if (clkSync_q[1] != filtClk_q) begin
      if (filtCnt_q == FCW'(FILTER_LEN - 1)) begin
        filtClk_d = clkSync_q[1];
        strobe_d  = filtClk_q;
      end else begin
        filtCnt_d = filtCnt_q + 1'b1;
      end
    end
  end

  // Deframer next state. Any non-idle state without a strobe counts
  // towards the timeout, which silently drops the partial frame.
  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    toCnt_d     = '0;
    byteValid_d = 1'b0;
    byte_d      = byte_q;
    perr_d      = 1'b0;
    ferr_d      = 1'b0;
    if (!en_i) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      if (strobe_q && !datBit) begin
        state_d  = ST_DATA;
        bitCnt_d = '0;
      end
    end else if (!strobe_q) begin
      if (timeoutHit) begin
        state_d = ST_IDLE;
      end else begin
        toCnt_d = toCnt_q + 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_DATA: begin
          shift_d  = {datBit, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 1'b1;
          if (bitCnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = datBit;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!datBit) begin
            ferr_d = 1'b1;
          end else if (!oddParityOk(shift_q, parity_q)) begin
            perr_d = 1'b1;
          end else begin
            byteValid_d = 1'b1;
            byte_d      = shift_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Conditioning and deframer registers; lines idle high after reset
  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      clkSync_q   <= 2'b11;
      datSync_q   <= 2'b11;
      filtClk_q   <= 1'b1;
      filtCnt_q   <= '0;
      strobe_q    <= 1'b0;
      state_q     <= ST_IDLE;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      toCnt_q     <= '0;
      byteValid_q <= 1'b0;
      byte_q      <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      clkSync_q   <= {clkSync_q[0], ps2Clk_i};
      datSync_q   <= {datSync_q[0], ps2Dat_i};
      filtClk_q   <= filtClk_d;
      filtCnt_q   <= filtCnt_d;
      strobe_q    <= strobe_d;
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      toCnt_q     <= toCnt_d;
      byteValid_q <= byteValid_d;
      byte_q      <= byte_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
    end
  end

  assign byteValid_o = byteValid_q;
  assign byte_o      = byte_q;
  assign perr_o      = perr_q;
  assign ferr_o      = ferr_q;

endmodule

// File: rtl/ps2_keyboard_mmio.sv
// ps2_keyboard_mmio
//   Memory-mapped PS/2 keyboard receiver: scan-code FIFO plus DATA,
//   STATUS and CTRL registers on the CPU bus.
//   Ports:
//     Clock, Reset_L          system clock, asynchronous active-low reset
//     Keyboard_Select_H, AS_L, WE_L, Address, DataIn   CPU bus inputs
//     DataOut                 read data, zero when not selected
//     PS2_CLK, PS2_DAT        keyboard lines (asynchronous)
//     IRQ_Keyboard_H          interrupt request
//   Build option: define PS2_KBD_IRQ_EN to store CTRL.IE and drive
//   IRQ_Keyboard_H = registered (IE & NOT_EMPTY); otherwise IRQ is 0.
module ps2_keyboard_mmio
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        Clock,
  input  logic        Reset_L,
  input  logic        Keyboard_Select_H,
  input  logic        AS_L,
  input  logic        WE_L,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  input  logic        PS2_CLK,
  input  logic        PS2_DAT,
  output logic        IRQ_Keyboard_H
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic          rxValid, rxPerr, rxFerr;
  logic [7:0]    rxByte;

  logic          access, wrStrobe, flush, pushReq, doPush, doPop, empty, full, ieBit;
  logic [1:0]    regSel;
  logic [31:0]   statusWord;
  logic          unusedBits;

  logic          access_q, rdData_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d, en_q, en_d;

  ps2_rx_frame #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) uRx (
    .clk_i       (Clock),
    .rstN_i      (Reset_L),
    .en_i        (en_q),
    .ps2Clk_i    (PS2_CLK),
    .ps2Dat_i    (PS2_DAT),
    .byteValid_o (rxValid),
    .byte_o      (rxByte),
    .perr_o      (rxPerr),
    .ferr_o      (rxFerr)
  );

  // Writes act only on the first cycle of an access; a DATA read pops on
  // the first edge after the access ends so the head is stable meanwhile.
  assign access   = Keyboard_Select_H & ~AS_L;
  assign regSel   = Address[3:2];
  assign wrStrobe = access & ~access_q & ~WE_L;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign flush    = wrStrobe && (regSel == REG_CTRL) && DataIn[CTRL_FLUSH];
  assign pushReq  = rxValid & en_q;
  assign doPush   = pushReq & ~full & ~flush;
  assign doPop    = rdData_q & ~access & ~empty & ~flush;

  // FIFO bookkeeping; flush overrides a same-cycle push or pop
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + 1'b1;
      if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
      if (doPush && !doPop)      count_d = count_q + 1'b1;
      else if (doPop && !doPush) count_d = count_q - 1'b1;
    end
  end

  // Sticky flags: write-1 clears, a new event in the same cycle wins
  always_comb begin
    ovf_d  = ovf_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    en_d   = en_q;
    if (wrStrobe && regSel == REG_STATUS) begin
      if (DataIn[STAT_OVF])  ovf_d  = 1'b0;
      if (DataIn[STAT_PERR]) perr_d = 1'b0;
      if (DataIn[STAT_FERR]) ferr_d = 1'b0;
    end
    if (wrStrobe && regSel == REG_CTRL) en_d = DataIn[CTRL_EN];
    if (pushReq && full && !flush) ovf_d = 1'b1;
    if (rxPerr) perr_d = 1'b1;
    if (rxFerr) ferr_d = 1'b1;
  end

  // Control, pointer and flag registers
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      access_q <= 1'b0;
      rdData_q <= 1'b0;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      en_q     <= 1'b1;
    end else begin
      access_q <= access;
      rdData_q <= access & WE_L & (regSel == REG_DATA);
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      en_q     <= en_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted
  always_ff @(posedge Clock) begin
    if (doPush) mem_q[wrPtr_q] <= rxByte;
  end

`ifdef PS2_KBD_IRQ_EN
  logic ie_q, irq_q;

  // IE storage and registered interrupt request
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wrStrobe && regSel == REG_CTRL) ie_q <= DataIn[CTRL_IE];
      irq_q <= ie_q & ~empty;
    end
  end

  assign ieBit          = ie_q;
  assign IRQ_Keyboard_H = irq_q;
`else
  assign ieBit          = 1'b0;
  assign IRQ_Keyboard_H = 1'b0;
`endif

  // Read mux; DATA shows the FIFO head only while it holds something
  always_comb begin
    statusWord                                = '0;
    statusWord[STAT_NOT_EMPTY]                = ~empty;
    statusWord[STAT_FULL]                     = full;
    statusWord[STAT_OVF]                      = ovf_q;
    statusWord[STAT_PERR]                     = perr_q;
    statusWord[STAT_FERR]                     = ferr_q;
    statusWord[STAT_COUNT_MSB:STAT_COUNT_LSB] = 6'(count_q);
    DataOut = '0;
    if (access) begin
      unique case (regSel)
        REG_DATA:   DataOut = empty ? 32'h0 : {23'b0, 1'b1, mem_q[rdPtr_q]};
        REG_STATUS: DataOut = statusWord;
        REG_CTRL:   DataOut = {30'b0, ieBit, en_q};
        REG_RSVD:   DataOut = '0;
        default:    DataOut = '0;
      endcase
    end
  end

  assign unusedBits = ^{Address[31:4], Address[1:0], DataIn};

endmodule

// File: tb/tb_ps2_keyboard_mmio.sv
// tb_ps2_keyboard_mmio
//   Self-checking bench for ps2_keyboard_mmio. Bytes are sent as PS/2 frames
//   and a queue-based model of the FIFO and sticky flags predicts every
//   register read. Honours PS2_KBD_IRQ_EN when the design is built with it.
module tb_ps2_keyboard_mmio;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        resetL, sel, asL, weL, ps2Clk, ps2Dat, irq;
  logic [31:0] addr, dIn, dOut;

  int assertCount = 0;
  int failCount   = 0;

  int modelQ[$];
  bit mOvf, mPerr, mFerr, mEn, mIe;

  always #5 clock = ~clock;

  ps2_keyboard_mmio #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(8), .TIMEOUT_CYCLES(50000)) dut (
    .Clock             (clock),
    .Reset_L           (resetL),
    .Keyboard_Select_H (sel),
    .AS_L              (asL),
    .WE_L              (weL),
    .Address           (addr),
    .DataIn            (dIn),
    .DataOut           (dOut),
    .PS2_CLK           (ps2Clk),
    .PS2_DAT           (ps2Dat),
    .IRQ_Keyboard_H    (irq)
  );

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitClocks(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [31:0] modelStatus();
    int n = modelQ.size();
    return (32'(n) << 5) | (32'(mFerr) << 4) | (32'(mPerr) << 3) | (32'(mOvf) << 2)
         | (32'(n == DEPTH) << 1) | 32'(n != 0);
  endfunction

  function automatic logic modelIrq();
`ifdef PS2_KBD_IRQ_EN
    return mIe && (modelQ.size() != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic busRead(input logic [1:0] regSel, output logic [31:0] data);
    @(negedge clock);
    sel = 1'b1; asL = 1'b0; weL = 1'b1; addr = {28'h0, regSel, 2'b00};
    waitClocks(2);
    data = dOut;
    sel = 1'b0; asL = 1'b1;
    waitClocks(3);
  endtask

  task automatic busWrite(input logic [1:0] regSel, input logic [31:0] data);
    @(negedge clock);
    sel = 1'b1; asL = 1'b0; weL = 1'b0; addr = {28'h0, regSel, 2'b00}; dIn = data;
    waitClocks(2);
    sel = 1'b0; asL = 1'b1; weL = 1'b1; dIn = '0;
    waitClocks(3);
  endtask

  // Drives one PS/2 bit: data set up, then a 15-clock low pulse on PS2_CLK
  task automatic sendBit(input logic b);
    ps2Dat = b;
    waitClocks(5);
    ps2Clk = 1'b0;
    waitClocks(15);
    ps2Clk = 1'b1;
    waitClocks(10);
  endtask

  // kind: 0 good frame, 1 inverted parity, 2 stop bit 0
  task automatic applyStimulus(input logic [7:0] code, input int kind);
    logic [10:0] bits;
    bits[0]    = 1'b0;
    bits[8:1]  = code;
    bits[9]    = ~(^code) ^ (kind == 1);
    bits[10]   = (kind != 2);
    for (int i = 0; i < 11; i++) sendBit(bits[i]);
    ps2Dat = 1'b1;
    waitClocks(20);
    if (mEn) begin
      if (kind == 1)                 mPerr = 1'b1;
      else if (kind == 2)            mFerr = 1'b1;
      else if (modelQ.size() < DEPTH) modelQ.push_back(int'(code));
      else                           mOvf = 1'b1;
    end
  endtask

  task automatic checkStatus(input string tag);
    logic [31:0] d;
    busRead(2'd1, d);
    checkOutput(tag, d, modelStatus());
  endtask

  task automatic checkData(input string tag);
    logic [31:0] d;
    logic [31:0] exp;
    exp = (modelQ.size() != 0) ? (32'h100 | 32'(modelQ[0])) : 32'h0;
    busRead(2'd0, d);
    checkOutput(tag, d, exp);
    if (modelQ.size() != 0) void'(modelQ.pop_front());
  endtask

  initial begin
    #(10 * 95000);
    $display("[TB] FAIL watchdog: simulation did not complete within cycle budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] d;
    sel = 1'b0; asL = 1'b1; weL = 1'b1; addr = '0; dIn = '0;
    ps2Clk = 1'b1; ps2Dat = 1'b1; resetL = 1'b0;
    mOvf = 0; mPerr = 0; mFerr = 0; mEn = 1; mIe = 0;
    waitClocks(5);
    resetL = 1'b1;
    waitClocks(2);

    $display("[TB] reset values");
    checkOutput("irq_reset", irq, 1'b0);
    checkStatus("status_reset");
    busRead(2'd2, d);
    checkOutput("ctrl_reset", d, 32'h1);
    checkData("data_reset");

    $display("[TB] single good frame 0x1C");
    applyStimulus(8'h1C, 0);
    checkOutput("dataout_unselected", dOut, 32'h0);
    checkStatus("status_one");
    checkData("data_1c");
    checkStatus("status_after_pop");
    checkData("data_empty");

    $display("[TB] parity error and clear");
    applyStimulus(8'h1C, 1);
    checkStatus("status_perr");
    busWrite(2'd1, 32'h08);
    mPerr = 0;
    checkStatus("status_perr_cleared");

    $display("[TB] overflow with 17 frames");
    for (int i = 0; i < 17; i++) applyStimulus(8'(i), 0);
    checkStatus("status_full_ovf");
    for (int i = 0; i < 16; i++) checkData($sformatf("drain_%0d", i));
    busWrite(2'd1, 32'h04);
    mOvf = 0;
    checkStatus("status_ovf_cleared");

    $display("[TB] timeout on partial frame");
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(1'($urandom_range(0, 1)));
    waitClocks(50010);
    applyStimulus(8'hF0, 0);
    checkStatus("status_after_timeout");
    checkData("data_f0");

    $display("[TB] glitches on PS2_CLK and stop-bit error");
    ps2Dat = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ps2Clk = 1'b0; waitClocks(3);
      ps2Clk = 1'b1; waitClocks(10);
    end
    ps2Dat = 1'b1;
    waitClocks(20);
    applyStimulus(8'h33, 0);
    checkData("data_after_glitch");
    applyStimulus(8'h44, 2);
    checkStatus("status_ferr");
    busWrite(2'd1, 32'h10);
    mFerr = 0;

    $display("[TB] receiver disabled");
    busWrite(2'd2, 32'h0);
    mEn = 0;
    applyStimulus(8'h77, 0);
    checkStatus("status_disabled");
    busWrite(2'd2, 32'h1);
    mEn = 1;

    $display("[TB] flush");
    applyStimulus(8'h12, 0);
    applyStimulus(8'h34, 0);
    busWrite(2'd2, 32'h5);
    modelQ.delete();
    checkStatus("status_flushed");
    busRead(2'd2, d);
    checkOutput("ctrl_after_flush", d, 32'h1);

    $display("[TB] interrupt");
    busWrite(2'd2, 32'h3);
    mIe = 1;
    busRead(2'd2, d);
`ifdef PS2_KBD_IRQ_EN
    checkOutput("ctrl_ie", d, 32'h3);
`else
    checkOutput("ctrl_ie", d, 32'h1);
`endif
    applyStimulus(8'h5A, 0);
    checkOutput("irq_pending", irq, modelIrq());
    checkData("data_5a");
    checkOutput("irq_after_pop", irq, modelIrq());

    $display("[TB] randomized frames and reads");
    for (int i = 0; i < 20; i++) begin
      int r;
      int kind;
      r = int'($urandom_range(0, 9));
      kind = (r < 7) ? 0 : ((r < 8) ? 1 : 2);
      applyStimulus(8'($urandom_range(0, 255)), kind);
      checkOutput($sformatf("irq_rand_%0d", i), irq, modelIrq());
      if ($urandom_range(0, 1) == 1) checkData($sformatf("data_rand_%0d", i));
      if (i % 5 == 4) begin
        checkStatus($sformatf("status_rand_%0d", i));
        busWrite(2'd1, 32'h1C);
        mOvf = 0; mPerr = 0; mFerr = 0;
      end
    end
    for (int i = 0; i < DEPTH && modelQ.size() != 0; i++) checkData($sformatf("data_final_%0d", i));
    checkStatus("status_final");

    $display("[TB] reset mid-frame");
    sendBit(1'b0);
    sendBit(1'b1);
    resetL = 1'b0;
    waitClocks(2);
    resetL = 1'b1;
    modelQ.delete();
    mOvf = 0; mPerr = 0; mFerr = 0; mEn = 1; mIe = 0;
    checkOutput("irq_after_reset", irq, 1'b0);
    checkStatus("status_after_reset");
    busRead(2'd2, d);
    checkOutput("ctrl_after_reset", d, 32'h1);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
